// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: DE/EX hazard signals between the pipeline (master) and the stall generator (slave)
interface pipe_hazard_ctrl_if;
  logic [4:0] de_rs1addr;
  logic [4:0] de_rs2addr;
  logic       de_rs1_used;
  logic       de_rs2_used;
  logic       de2ex_load_ffout;
  logic       de2ex_wr_reg_ffout;
  logic [4:0] de2ex_wr_regindex_ffout;
  logic       de2ex_MD_OP_ffout;
  logic       de2ex_md_div;
  logic       md_div_zero;
  logic       memacc_stall;
  logic       mem2wb_exp_ffout;
  logic       de_stall;
  logic       exe_stall;
  logic       md_busy;
  logic       md_done;
  modport master (
    output de_rs1addr, de_rs2addr, de_rs1_used, de_rs2_used, de2ex_load_ffout, de2ex_wr_reg_ffout,
           de2ex_wr_regindex_ffout, de2ex_MD_OP_ffout, de2ex_md_div, md_div_zero, memacc_stall,
           mem2wb_exp_ffout,
    input  de_stall, exe_stall, md_busy, md_done
  );
  modport slave (
    input  de_rs1addr, de_rs2addr, de_rs1_used, de_rs2_used, de2ex_load_ffout, de2ex_wr_reg_ffout,
           de2ex_wr_regindex_ffout, de2ex_MD_OP_ffout, de2ex_md_div, md_div_zero, memacc_stall,
           mem2wb_exp_ffout,
    output de_stall, exe_stall, md_busy, md_done
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use interlock plus multiply/divide EX sequencer (sequencer built only with PIPE_HAZARD_MD_EN)
module pipe_hazard_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 33
) (
  input logic clk,
  input logic cpurst,
  pipe_hazard_ctrl_if.slave hz
);
  assign hz.de_stall = hz.de2ex_load_ffout & hz.de2ex_wr_reg_ffout & (hz.de2ex_wr_regindex_ffout != 5'd0) &
                       ((hz.de_rs1_used & (hz.de_rs1addr == hz.de2ex_wr_regindex_ffout)) |
                        (hz.de_rs2_used & (hz.de_rs2addr == hz.de2ex_wr_regindex_ffout)));
`ifdef PIPE_HAZARD_MD_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t     state;
  logic [5:0] cnt;
  logic [5:0] start_cnt;
  logic       start_done;
  logic       busy;
  logic       done;
  assign start_cnt  = hz.de2ex_md_div ? 6'(DIV_CYCLES - 2) : 6'(MUL_CYCLES - 2);
  assign start_done = (hz.de2ex_md_div & hz.md_div_zero) | (start_cnt == 6'd0);
  // cnt holds the stall cycles still owed in BUSY, so DONE lands on the last EX cycle
  always_ff @(posedge clk) begin
    if (cpurst | hz.mem2wb_exp_ffout) begin
      state <= IDLE;
      cnt   <= 6'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (hz.de2ex_MD_OP_ffout) begin
          state <= start_done ? DONE : BUSY;
          cnt   <= start_done ? 6'd0 : start_cnt;
          busy  <= ~start_done;
          done  <= start_done;
        end
        BUSY: if (cnt <= 6'd1) begin
          state <= DONE;
          cnt   <= 6'd0;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          cnt <= cnt - 6'd1;
        end
        DONE: if (!hz.memacc_stall) begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          cnt   <= 6'd0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
  assign hz.exe_stall = hz.de2ex_MD_OP_ffout & ~done;
  assign hz.md_busy   = busy;
  assign hz.md_done   = done;
`else
  logic unused;
  assign unused = ^{clk, cpurst, hz.de2ex_MD_OP_ffout, hz.de2ex_md_div, hz.md_div_zero, hz.memacc_stall,
                    hz.mem2wb_exp_ffout, 6'(MUL_CYCLES), 6'(DIV_CYCLES)};
  assign hz.exe_stall = 1'b0;
  assign hz.md_busy   = 1'b0;
  assign hz.md_done   = 1'b0;
`endif
endmodule
